ofifo_col_bank: RTL
===================

# ofifo_col_bank

Output FIFO bank directly downstream of the special-function (accumulate/ReLU) stage. It holds one independent FIFO per column and writes each column from that stage's per-column write enables and packed `out_accum` bus. It pops all columns together as one row vector when every column holds data. The host/readout side drains complete output rows from it.

## Interface
Parameters:
- `col`, 8, number of columns (one FIFO each)
- `bw`, 16, data width per column (matches psum width)
- `depth`, 64, entries per column FIFO; power of two, ≥ 2

Ports:
- `clk`  input  1  single clock, rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `in`  input  `bw*col`  packed column data; column k at `[(k+1)*bw-1 : k*bw]`
- `wr`  input  `col`  per-column write request (driven by upstream `wr_ofifo`)
- `rd`  input  1  row read request
- `out`  output  `bw*col`  registered row read data, same packing as `in`
- `o_valid`  output  1  every column non-empty (a row is available)
- `o_full`  output  1  any column full
- `out_vld`  output  1  `out` holds data popped in the previous cycle
- `ovf_cnt`  output  16  overflow event counter (see Configuration)

## Operation
- Each column has its own write pointer, read pointer and occupancy count (`log2(depth)+1` bits). Pointers wrap modulo `depth`.
- Write, column k: accepted when `wr[k]` and (count_k < depth, or a row read is accepted in the same cycle). The accepted entry is stored at wptr_k, and wptr_k increments.
- Write to a full column with no simultaneous read is dropped. Data and pointers are unchanged, and one overflow event is counted per dropped column per cycle.
- Row read: accepted when `rd && o_valid`. Every column's rptr increments, and every column's entry is registered into `out`.
- `rd` while `!o_valid` is ignored: no pointer change, `out` holds its value, and `out_vld` goes to 0.
- Simultaneous accepted write and read on a column: count unchanged, both pointers advance. On an empty column the write does not bypass to the read.
- `o_valid` = AND of (count_k != 0). `o_full` = OR of (count_k == depth). Both are combinational from the counts.
- Columns drift by at most their occupancy difference. Ragged rows are legal; a row pops only when all columns have data.

## Timing
- Reset (async assert, sync release): all pointers and counts go to 0. `out` = 0, `out_vld` = 0, `o_valid` = 0, `o_full` = 0, `ovf_cnt` = 0. Assertion mid-operation discards all contents immediately.
- Write latency: an entry written in cycle N is counted in cycle N+1. `o_valid` can rise in N+1 at the earliest.
- Read latency: `rd` accepted in cycle N puts data on `out` with `out_vld` = 1 in cycle N+1. `out_vld` is 0 in any cycle not preceded by an accepted read.
- Back-to-back reads: one row per cycle while `o_valid` stays high.
- Memory contents are not reset. Only pointers, counts and output registers are reset.

## Configuration
- `OFIFO_OVF_CNT_EN` defined: `ovf_cnt` is a 16-bit counter. It increments by the number of columns whose write was dropped in that cycle, and saturates at 0xFFFF.
- Not defined: `ovf_cnt` is tied to 0, no counter logic is built, and dropped writes are silent. FIFO behaviour is otherwise identical.

## Structure
- Package `ofifo_pkg`: default `col`/`bw`/`depth` constants, `ptr_w = $clog2(depth)`, and the `ovf_cnt` width constant (16).
- Sub-module `ofifo_col` (single-column FIFO: storage array, wptr/rptr/count, `full`/`empty`, and `wr_ok`/`ovf` strobes) is instantiated `col` times in a generate loop.
- The top level holds the row-read logic, the `out`/`out_vld` registers and the overflow counter.

## Test plan
- Reset, then write column data 0x0001..0x0008 with `wr` = 0xFF, then `rd` → next cycle `out` = {0x0008,…,0x0001} and `out_vld` = 1; `o_valid` then falls to 0.
- Write only columns 0–6 (`wr` = 0x7F), 3 times → `o_valid` stays 0. One `wr` = 0x80 write → `o_valid` = 1, and the first read returns the first-written values in every column.
- Fill all columns to 64 entries → `o_full` = 1. A further `wr` = 0xFF write is dropped and `ovf_cnt` = 8 with the macro, 0 without. Subsequent reads return the original 64 rows in order.
- Full bank, same cycle `rd` = 1 and `wr` = 0xFF → both accepted, counts stay 64, and the new row appears after 64 more reads.
- Stream 200 rows with interleaved reads → pointer wrap is transparent and data order is preserved.
- Pull `reset_n` low mid-stream → outputs are zero immediately. After release, `o_valid` = 0 and a `rd` gives `out_vld` = 0.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared constants for the per-column output FIFO bank.
package ofifo_pkg;

    localparam int COL   = 8;              // default column count
    localparam int BW    = 16;             // default data width per column
    localparam int DEPTH = 64;             // default entries per column (power of two)
    localparam int PTR_W = $clog2(DEPTH);  // pointer width for the default depth
    localparam int OVF_W = 16;             // overflow event counter width

endpackage : ofifo_pkg

// File: rtl/ofifo_col.sv
// Single-column FIFO: storage array, write/read pointers and occupancy count.
// `rd` is the bank-level accepted row read; the bank only asserts it when every
// column (this one included) is non-empty, so no empty guard is needed here.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          wr_ok,
    output logic          ovf
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [bw-1:0] mem [depth];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full  = (cnt_q == CW'(depth));
    assign empty = (cnt_q == '0);
    // A full column still accepts a write when a row read frees a slot this cycle.
    assign wr_ok = wr && (!full || rd);
    assign ovf   = wr && full && !rd;
    assign dout  = mem[rptr_q];

    // Next-state pointers and occupancy; pointers wrap naturally at depth.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok) wptr_d = wptr_q + PW'(1);
        if (rd)    rptr_d = rptr_q + PW'(1);
        if (wr_ok && !rd)      cnt_d = cnt_q + CW'(1);
        else if (!wr_ok && rd) cnt_d = cnt_q - CW'(1);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= din;
    end

endmodule : ofifo_col

// File: rtl/ofifo_col_bank.sv
// Output FIFO bank: one FIFO per column, rows popped together when all columns
// hold data. Define OFIFO_OVF_CNT_EN to build the saturating overflow counter;
// otherwise ovf_cnt is tied to zero.
module ofifo_col_bank
    import ofifo_pkg::*;
#(
    parameter int col   = COL,
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [bw*col-1:0]    in,
    input  logic [col-1:0]       wr,
    input  logic                 rd,
    output logic [bw*col-1:0]    out,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 out_vld,
    output logic [OVF_W-1:0]     ovf_cnt
);

    logic [bw*col-1:0] row_data;
    logic [col-1:0]    col_full;
    logic [col-1:0]    col_empty;
    logic [col-1:0]    col_wr_ok;
    logic [col-1:0]    col_ovf;
    logic              rd_ok;

    logic [bw*col-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;

    assign o_valid = ~|col_empty;
    assign o_full  = |col_full;
    assign rd_ok   = rd && o_valid;

    for (genvar g = 0; g < col; g++) begin : g_col
        ofifo_col #(
            .bw    (bw),
            .depth (depth)
        ) u_col (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr[g]),
            .rd      (rd_ok),
            .din     (in[g*bw +: bw]),
            .dout    (row_data[g*bw +: bw]),
            .full    (col_full[g]),
            .empty   (col_empty[g]),
            .wr_ok   (col_wr_ok[g]),
            .ovf     (col_ovf[g])
        );
    end

    // Row output register: capture the head row on an accepted read, else hold.
    always_comb begin
        out_d     = out_q;
        out_vld_d = rd_ok;
        if (rd_ok) out_d = row_data;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out     = out_q;
    assign out_vld = out_vld_q;

`ifdef OFIFO_OVF_CNT_EN
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [OVF_W:0]   ovf_sum;
    logic             unused_wr_ok;

    assign unused_wr_ok = ^col_wr_ok;

    // Add this cycle's dropped-column count, saturating at all ones.
    always_comb begin
        ovf_sum = {1'b0, ovf_q};
        for (int unsigned k = 0; k < col; k++) begin
            ovf_sum = ovf_sum + (OVF_W+1)'(col_ovf[k]);
        end
        ovf_d = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    end

    // Overflow counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_q <= '0;
        else          ovf_q <= ovf_d;
    end

    assign ovf_cnt = ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf = ^{col_ovf, col_wr_ok};
    assign ovf_cnt    = '0;
`endif

endmodule : ofifo_col_bank
